program_sequencer: RTL
======================

# program_sequencer

Parametrised successor to the single-cycle instruction decoder. It decodes the 16-bit ISA word into register-file and ALU controls, and owns the program counter. It adds:
- a fetch-valid stall handshake,
- register-value-qualified conditional copy and conditional halt,
- a RUN/HALTED state machine with resume,
- a CALL/RET return-address stack with sticky over/underflow detection.

It sits between instruction memory and the datapath; `cond_data` is the register-file read of the A address.

## Interface
- `ADDR_W`, 8: PC width, 1..8. Jump and call targets are `instr[ADDR_W-1:0]`.
- `DATA_W`, 8: datapath width, ≥1.
- `STACK_DEPTH`, 4: return-stack entries, ≥1.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `instr` in 16: instruction word at `pc`.
- `instr_valid` in 1: `instr` is valid this cycle.
- `cond_data` in `DATA_W`: register-file value addressed by `a_addr`.
- `ext_data` in `DATA_W`: external switch input.
- `resume` in 1: leave HALTED (level-sampled).
- `pc` out `ADDR_W`: instruction address.
- `dest_addr`, `b_addr`, `a_addr` out 4 each: `instr[11:8]`, `[7:4]`, `[3:0]`.
- `write_src_sel` out 1: 1 = `imm_data`, 0 = ALU.
- `mux_b_sel` out 1: 1 = immediate operand.
- `alu_op` out 4: ALU operation.
- `write_en` out 1: register write strobe.
- `imm_data` out `DATA_W`: immediate or external data.
- `halted` out 1: state == HALTED.
- `stack_err` out 1: sticky stack over/underflow.
- `sp` out `$clog2(STACK_DEPTH+1)`: stack occupancy.

## Operation
- **Decode is combinational** from `instr`.
  - Defaults: `write_en`=1, `alu_op`=0000, selects 0.
  - `imm_data` = `instr[7:0]`, zero-extended or truncated to `DATA_W`.
- **Opcodes:**
  - 0000 SET: `write_src_sel`=1, `mux_b_sel`=1.
  - 0001 LOAD: `write_src_sel`=1, `imm_data`=`ext_data`.
  - 0010 COPY: `alu_op`=0001.
  - 0011 CCOPY: `alu_op`=0001; `write_en` = (`cond_data`≠0).
  - 0100 ADD → 0010; 0101 NEG → 0011; 0110 AND → 0100; 0111 OR → 0101; 1010 EQ → 1000; 1011 GT → 1001.
  - 1000 SHL → 0110 and 1001 SHR → 0111, both with `mux_b_sel`=1.
  - 1100 with `instr[11:8]`=0: CALL. With `instr[11:8]`=1: RET. Other `instr[11:8]` values: NOP. `write_en`=0 in all cases.
  - 1101 JMP; 1110 HALT; 1111 CHALT (halt if `cond_data`≠0). `write_en`=0 for all three.
- **Write gating:** `write_en` is forced 0 unless `instr_valid`=1 and state = RUN.
- **State RUN.** With `instr_valid`=0, `pc` holds. Otherwise, at the clock edge:
  - JMP: `pc` ← target.
  - CALL, `sp`<`STACK_DEPTH`: push `pc+1`, `sp`+1, `pc` ← target.
  - RET, `sp`>0: `sp`−1, `pc` ← popped entry.
  - CALL when full, or RET when empty: no push/pop, `stack_err` ← 1, → HALTED, `pc` holds.
  - HALT, or CHALT with `cond_data`≠0: → HALTED, `pc` holds at the halt instruction.
  - CHALT with `cond_data`=0, and all other opcodes: `pc` ← `pc+1`.
- **State HALTED.** `pc`, `sp` and the stack hold.
  - `resume`=1 with `stack_err`=0: `pc` ← `pc+1`, → RUN.
  - `resume` is ignored while `stack_err`=1; only `rst` clears the error.
- **Width rules:**
  - `pc` increments modulo 2^`ADDR_W`, so `pc+1` wraps to 0.
  - Pushed addresses wrap the same way.
- **Unused input:** `resume` in RUN is ignored.

## Timing
- **Reset (async, any state, mid-call included):** `pc`=0, state RUN, `halted`=0, `sp`=0, `stack_err`=0. Stack contents are don't-care.
- **Decode latency:** 0 cycles; outputs follow `instr` combinationally.
- **Control transfer:** `pc` update, stack push/pop and state change all take effect at the same rising edge that consumes a valid instruction.
- **Resume:** `halted` falls 1 cycle after `resume` is sampled high.
- **Stalls:** no registered side effects while `instr_valid`=0.

## Test plan
- **Reset and sequencing:** reset, 3 valid ADDs → `pc` 0,1,2,3; `write_en`=1, `alu_op`=0010. Drop `instr_valid` for 2 cycles → `pc` holds at 3, `write_en`=0.
- **Call/return:** CALL 0x40 at `pc`=5 → `pc`=0x40, `sp`=1. RET → `pc`=6, `sp`=0.
- **Stack overflow:** `STACK_DEPTH`=2, three nested CALLs → third sets `stack_err`=1, `halted`=1, `sp`=2, `pc` holds. `resume` → no change. `rst` → all cleared.
- **Underflow:** RET with `sp`=0 → `stack_err`=1, `halted`=1.
- **Conditional ops:** CCOPY with `cond_data`=0 → `write_en`=0; with `cond_data`=0x80 → `write_en`=1. CHALT at `pc`=9 with `cond_data`=0 → `pc`=10. CHALT at `pc`=9 with `cond_data`=1 → `halted`=1, `pc`=9. `resume` → `pc`=10, RUN.
- **Wrap and widths:** `ADDR_W`=4, `pc`=15, ADD → `pc`=0. LOAD with `ext_data`=0xA5 → `imm_data`=0xA5, `write_src_sel`=1.

Source files
------------

// File: rtl/program_sequencer.sv
// program_sequencer
//   Decodes the 16-bit ISA word into register-file / ALU controls and owns
//   the program counter, a RUN/HALTED state machine and a CALL/RET
//   return-address stack with sticky over/underflow detection.
//
// Ports
//   clk, rst             : clock (rising edge), async active-high reset
//   instr, instr_valid   : instruction word at pc and its valid qualifier
//   cond_data            : register-file value addressed by a_addr
//   ext_data             : external switch input (LOAD source)
//   resume               : leave HALTED (level-sampled, ignored on error)
//   pc                   : instruction address
//   dest/b/a_addr        : register fields instr[11:8] / [7:4] / [3:0]
//   write_src_sel        : 1 = imm_data, 0 = ALU result
//   mux_b_sel            : 1 = immediate ALU operand
//   alu_op, write_en     : ALU operation and register write strobe
//   imm_data             : immediate or external data
//   halted, stack_err, sp: state, sticky stack error, stack occupancy
module program_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [15:0]                        instr,
  input  logic                               instr_valid,
  input  logic [DATA_W-1:0]                  cond_data,
  input  logic [DATA_W-1:0]                  ext_data,
  input  logic                               resume,
  output logic [ADDR_W-1:0]                  pc,
  output logic [3:0]                         dest_addr,
  output logic [3:0]                         b_addr,
  output logic [3:0]                         a_addr,
  output logic                               write_src_sel,
  output logic                               mux_b_sel,
  output logic [3:0]                         alu_op,
  output logic                               write_en,
  output logic [DATA_W-1:0]                  imm_data,
  output logic                               halted,
  output logic                               stack_err,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       pc_q, pc_d;
  logic [SP_W-1:0]         sp_q, sp_d;
  logic                    err_q, err_d;
  logic [ADDR_W-1:0]       stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0]       stack_d [STACK_DEPTH];

  logic [3:0]              opcode_s;
  logic                    cond_nz_s;
  logic                    base_we_s;
  logic [ADDR_W-1:0]       pc_inc_s;
  logic [ADDR_W-1:0]       target_s;
  logic [IDX_W-1:0]        push_idx_s;
  logic [IDX_W-1:0]        pop_idx_s;
  logic [DATA_W+7:0]       imm_ext_s;

  assign opcode_s   = instr[15:12];
  assign cond_nz_s  = |cond_data;
  assign pc_inc_s   = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};   // wraps modulo 2^ADDR_W
  assign target_s   = instr[ADDR_W-1:0];
  assign push_idx_s = sp_q[IDX_W-1:0];
  assign pop_idx_s  = IDX_W'(sp_q - {{(SP_W-1){1'b0}}, 1'b1});
  // Zero-extend first so the slice works for DATA_W both below and above 8.
  assign imm_ext_s  = {{DATA_W{1'b0}}, instr[7:0]};

  assign dest_addr = instr[11:8];
  assign b_addr    = instr[7:4];
  assign a_addr    = instr[3:0];

  // Combinational instruction decode.
  always_comb begin
    base_we_s     = 1'b1;
    alu_op        = 4'b0000;
    write_src_sel = 1'b0;
    mux_b_sel     = 1'b0;
    imm_data      = imm_ext_s[DATA_W-1:0];
    case (opcode_s)
      4'b0000: begin write_src_sel = 1'b1; mux_b_sel = 1'b1; end
      4'b0001: begin write_src_sel = 1'b1; imm_data = ext_data; end
      4'b0010: alu_op = 4'b0001;
      4'b0011: begin alu_op = 4'b0001; base_we_s = cond_nz_s; end
      4'b0100: alu_op = 4'b0010;
      4'b0101: alu_op = 4'b0011;
      4'b0110: alu_op = 4'b0100;
      4'b0111: alu_op = 4'b0101;
      4'b1000: begin alu_op = 4'b0110; mux_b_sel = 1'b1; end
      4'b1001: begin alu_op = 4'b0111; mux_b_sel = 1'b1; end
      4'b1010: alu_op = 4'b1000;
      4'b1011: alu_op = 4'b1001;
      4'b1100, 4'b1101, 4'b1110, 4'b1111: base_we_s = 1'b0;
      default: base_we_s = 1'b0;
    endcase
    // Writes only happen for a consumed instruction while running.
    write_en = base_we_s & instr_valid & (state_q == RUN);
  end

  // Next-state logic for pc, state, stack pointer, stack and error flag.
  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    state_d = state_q;
    err_d   = err_q;
    stack_d = stack_q;
    case (state_q)
      RUN: begin
        if (instr_valid) begin
          case (opcode_s)
            4'b1100: begin
              if (instr[11:8] == 4'd0) begin
                if (sp_q != SP_FULL) begin
                  stack_d[push_idx_s] = pc_inc_s;
                  sp_d  = sp_q + {{(SP_W-1){1'b0}}, 1'b1};
                  pc_d  = target_s;
                end else begin
                  err_d   = 1'b1;
                  state_d = HALTED;
                end
              end else if (instr[11:8] == 4'd1) begin
                if (sp_q != {SP_W{1'b0}}) begin
                  sp_d = sp_q - {{(SP_W-1){1'b0}}, 1'b1};
                  pc_d = stack_q[pop_idx_s];
                end else begin
                  err_d   = 1'b1;
                  state_d = HALTED;
                end
              end else begin
                pc_d = pc_inc_s;
              end
            end
            4'b1101: pc_d = target_s;
            4'b1110: state_d = HALTED;
            4'b1111: begin
              if (cond_nz_s) begin
                state_d = HALTED;
              end else begin
                pc_d = pc_inc_s;
              end
            end
            default: pc_d = pc_inc_s;
          endcase
        end else begin
          pc_d = pc_q;
        end
      end
      HALTED: begin
        // A stack error is only cleared by reset, so resume is locked out.
        if (resume && !err_q) begin
          pc_d    = pc_inc_s;
          state_d = RUN;
        end else begin
          state_d = HALTED;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Control state registers with async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= {ADDR_W{1'b0}};
      sp_q    <= {SP_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
    end
  end

  // Return-address storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign pc        = pc_q;
  assign sp        = sp_q;
  assign stack_err = err_q;
  assign halted    = (state_q == HALTED);

endmodule
